// File: rtl/dec_pp_accumulator_if.sv
// Handshake bundle between the multiple-generation stage, the partial-product
// accumulator and the product consumer.
interface dec_pp_accumulator_if #(
    parameter int NDIG = 4,
    parameter int NPP  = 4
);
    logic [4*(NDIG+1)-1:0]   pp_in;
    logic                    in_valid;
    logic                    in_ready;
    logic [4*(NDIG+NPP)-1:0] prod;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output pp_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  prod,
        input  out_valid
    );

    modport slave (
        input  pp_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output prod,
        output out_valid
    );
endinterface

// File: rtl/dec_pp_accumulator.sv
// Sequential decimal partial-product accumulator: sums NPP BCD-4221 partial
// products with weights 10^k and emits the exact product in BCD-8421.
module dec_pp_accumulator #(
    parameter int NDIG = 4,
    parameter int NPP  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dec_pp_accumulator_if.slave  bus
);
    localparam int PPW   = 4*(NDIG+1);
    localparam int PW    = 4*(NDIG+NPP);
    localparam int ACC_W = $clog2(10**(NDIG+NPP));
    localparam int KW    = $clog2(NPP)+1;

    typedef enum logic [1:0] {ACC, CONV, OUT} state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [PW-1:0]      prod_q, prod_d;

    // The running sum is kept in binary; every input is folded in exactly, so
    // the only decimal work left is a single binary-to-BCD pass in CONV.
    function automatic logic [ACC_W-1:0] pp_value(input logic [PPW-1:0] pp);
        logic [ACC_W-1:0] v;
        logic [3:0]       d;
        v = '0;
        for (int i = NDIG; i >= 0; i--) begin
            d = pp[4*i +: 4];
            v = v*ACC_W'(10) + ACC_W'({1'b0, d[3], 2'b00} + {2'b00, d[2], 1'b0}
                                    + {2'b00, d[1], 1'b0} + {3'b000, d[0]});
        end
        return v;
    endfunction

    function automatic logic [ACC_W-1:0] pow10(input logic [KW-1:0] k);
        logic [ACC_W-1:0] p;
        p = ACC_W'(1);
        for (int i = 0; i < NPP-1; i++) begin
            if (KW'(i) < k) begin
                p = p*ACC_W'(10);
            end
        end
        return p;
    endfunction

    function automatic logic [PW-1:0] bin2bcd(input logic [ACC_W-1:0] bin);
        logic [PW-1:0] b;
        b = '0;
        for (int i = ACC_W-1; i >= 0; i--) begin
            for (int j = 0; j < NDIG+NPP; j++) begin
                if (b[4*j +: 4] >= 4'd5) begin
                    b[4*j +: 4] = b[4*j +: 4] + 4'd3;
                end
            end
            b = {b[PW-2:0], bin[i]};
        end
        return b;
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        case (state_q)
            ACC: begin
                if (bus.in_valid) begin
                    acc_d = acc_q + pp_value(bus.pp_in)*pow10(k_q);
                    k_d   = k_q + KW'(1);
                    if (k_q == KW'(NPP-1)) begin
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                prod_d  = bin2bcd(acc_q);
                state_d = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            k_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.in_ready  = (state_q == ACC) && !rst;
    assign bus.out_valid = (state_q == OUT);
    assign bus.prod      = prod_q;
endmodule
